// File: rtl/i8080_bus_ctrl_if.sv
// CPU-side and device-side bus signals of the 8080 system-bus controller.
// Latency: none, wires only.
// Backpressure: none; wait states are expressed through ce.
interface i8080_bus_ctrl_if #(
    parameter int NUM_MEM = 4,
    parameter int NUM_IO  = 4
);
    logic [15:0]          addr;
    logic [7:0]           odata;
    logic                 sync;
    logic                 rd;
    logic                 wr_n;
    logic                 ce;
    logic [7:0]           idata;
    logic [7:0]           status;
    logic [NUM_MEM-1:0]   mem_rd;
    logic [NUM_MEM-1:0]   mem_we;
    logic [NUM_MEM*8-1:0] mem_data;
    logic [NUM_IO-1:0]    io_rd;
    logic [NUM_IO-1:0]    io_we;
    logic [NUM_IO*8-1:0]  io_data;
    logic                 unmapped;

    // Controller side.
    modport master (
        input  addr, odata, sync, rd, wr_n, mem_data, io_data,
        output ce, idata, status, mem_rd, mem_we, io_rd, io_we, unmapped
    );

    // CPU / device side.
    modport slave (
        output addr, odata, sync, rd, wr_n, mem_data, io_data,
        input  ce, idata, status, mem_rd, mem_we, io_rd, io_we, unmapped
    );
endinterface

// File: rtl/i8080_bus_ctrl.sv
// i8080 system-bus controller: CPU clock enable, status latch, region/port decode, wait states, read mux.
// Latency: strobes, idata and unmapped are combinational from addr/rd/wr_n; status follows sync by one clock.
// Backpressure: a region's wait states hold ce low for MEM_WAIT*CE_DIV clocks; strobes and idata stay valid.
module i8080_bus_ctrl #(
    parameter int                   CE_DIV   = 2,
    parameter int                   NUM_MEM  = 4,
    parameter int                   NUM_IO   = 4,
    parameter logic [NUM_MEM*16-1:0] MEM_BASE = '0,
    parameter logic [NUM_MEM*16-1:0] MEM_MASK = '0,
    parameter logic [NUM_MEM-1:0]    MEM_RO   = '0,
    parameter logic [NUM_MEM*4-1:0]  MEM_WAIT = '0,
    parameter logic [NUM_IO*8-1:0]   IO_BASE  = '0,
    parameter logic [NUM_IO*8-1:0]   IO_MASK  = '0,
    parameter logic [7:0]            INTA_VEC = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    i8080_bus_ctrl_if.master       bus
);
    localparam int DW = $clog2(CE_DIV);
    localparam int WW = $clog2(15 * CE_DIV + 1);

    logic [DW-1:0]      div_q, div_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [7:0]         status_q, status_d;
    logic               acc_q, acc_d;

    logic               is_io, is_inta, is_mem;
    logic [NUM_MEM-1:0] mem_hit;
    logic               mem_any;
    logic [7:0]         mem_rdata;
    logic [3:0]         hit_wait;
    logic [NUM_IO-1:0]  io_hit;
    logic               io_any;
    logic [7:0]         io_rdata;
    logic               acc, start, load, tc, suppress;
    logic [WW-1:0]      load_val;

    // Access type from the latched status byte; I/O takes priority over INTA.
    assign is_io   = status_q[6] | status_q[4];
    assign is_inta = ~is_io & status_q[0];
    assign is_mem  = ~is_io & ~status_q[0];

    // Memory region decode: first matching region wins and supplies data and wait count.
    always_comb begin
        mem_hit   = '0;
        mem_any   = 1'b0;
        mem_rdata = 8'h00;
        hit_wait  = 4'd0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (!mem_any && is_mem &&
                ((bus.addr & MEM_MASK[i*16 +: 16]) == MEM_BASE[i*16 +: 16])) begin
                mem_any    = 1'b1;
                mem_hit[i] = 1'b1;
                mem_rdata  = bus.mem_data[i*8 +: 8];
                hit_wait   = MEM_WAIT[i*4 +: 4];
            end
        end
    end

    // I/O port decode on the low address byte: first matching group wins.
    always_comb begin
        io_hit   = '0;
        io_any   = 1'b0;
        io_rdata = 8'h00;
        for (int j = 0; j < NUM_IO; j++) begin
            if (!io_any && is_io &&
                ((bus.addr[7:0] & IO_MASK[j*8 +: 8]) == IO_BASE[j*8 +: 8])) begin
                io_any    = 1'b1;
                io_hit[j] = 1'b1;
                io_rdata  = bus.io_data[j*8 +: 8];
            end
        end
    end

    // Per-target strobes; writes into read-only regions are simply not forwarded.
    assign bus.mem_rd = {NUM_MEM{bus.rd}} & mem_hit;
    assign bus.mem_we = {NUM_MEM{~bus.wr_n}} & mem_hit & ~MEM_RO;
    assign bus.io_rd  = {NUM_IO{bus.rd}} & io_hit;
    assign bus.io_we  = {NUM_IO{~bus.wr_n}} & io_hit;

    // Read data mux back to the CPU; open bus reads as 8'hFF.
    always_comb begin
        bus.idata = 8'hFF;
        if (is_inta) begin
            bus.idata = INTA_VEC;
        end else if (mem_any) begin
            bus.idata = mem_rdata;
        end else if (io_any) begin
            bus.idata = io_rdata;
        end
    end

    // Access start is the rising edge of (rd | ~wr_n); only memory hits load wait states.
    assign acc      = bus.rd | ~bus.wr_n;
    assign start    = acc & ~acc_q;
    assign load     = start & mem_any;
    assign load_val = WW'(hit_wait) * WW'(CE_DIV);
    assign tc       = (div_q == DW'(CE_DIV - 1)) && (wait_q == '0);
    // A wait load on the terminal-count clock takes that ce pulse away.
    assign suppress = load && (load_val != '0);

    assign bus.ce       = tc & ~suppress & ~reset;
    assign bus.unmapped = start & ~mem_any & ~io_any & ~is_inta & ~reset;
    assign bus.status   = status_q;

    // Next state: divider runs unless a wait is counting down; a new load overrides the count.
    always_comb begin
        status_d = bus.sync ? bus.odata : status_q;
        acc_d    = acc;
        div_d    = div_q;
        wait_d   = wait_q;
        if (wait_q != '0) begin
            wait_d = wait_q - WW'(1);
        end else if (div_q == DW'(CE_DIV - 1)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        if (load) begin
            wait_d = load_val;
        end
    end

    // State registers with synchronous reset; reset also aborts any wait in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            wait_q   <= '0;
            status_q <= 8'h00;
            acc_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            wait_q   <= wait_d;
            status_q <= status_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: doc/i8080_bus_ctrl.md
# i8080_bus_ctrl

Parametrised system-bus controller for 8080-based boards: generates the CPU clock enable, latches the status byte at `sync`, decodes the CPU address/status into N memory regions and M I/O ports, inserts per-region wait states by stretching `ce`, and muxes read data back to the CPU. It sits between the `i8080` core and the ROM/RAM/peripheral instances in a board top, replacing hand-written per-board decode.

## Interface
- `CE_DIV`, 2: clocks per CPU clock enable (≥2, so synchronous memories have one clock to respond).
- `NUM_MEM`, 4: number of memory regions (1..8).
- `NUM_IO`, 4: number of I/O port groups (1..8).
- `MEM_BASE`, 0: packed `NUM_MEM*16`; region i base (address bits outside the mask must be 0).
- `MEM_MASK`, 0: packed `NUM_MEM*16`; region i compare mask.
- `MEM_RO`, 0: `NUM_MEM` bits; bit i set makes region i read-only.
- `MEM_WAIT`, 0: packed `NUM_MEM*4`; extra CE periods per access to region i (0..15).
- `IO_BASE` / `IO_MASK`, 0: packed `NUM_IO*8`; port group j compare on `addr[7:0]`.
- `INTA_VEC`, 8'hFF: opcode returned during interrupt acknowledge (RST 7).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `addr` in 16: CPU address.
- `odata` in 8: CPU data out (status byte during `sync`, write data otherwise).
- `sync` in 1: CPU status strobe.
- `rd` in 1: CPU read strobe, active high.
- `wr_n` in 1: CPU write strobe, active low.
- `ce` out 1: CPU clock enable.
- `idata` out 8: read data to CPU.
- `status` out 8: latched status byte.
- `mem_rd` / `mem_we` out `NUM_MEM`: per-region read / write strobes.
- `mem_data` in `NUM_MEM*8`: per-region read data.
- `io_rd` / `io_we` out `NUM_IO`: per-group read / write strobes.
- `io_data` in `NUM_IO*8`: per-group read data.
- `unmapped` out 1: one-clock pulse on the first clock of an access that hits nothing.

## Operation
- Status bits: D0 INTA, D4 OUT, D6 INP; all others ignored by decode.
- Status latch: `status <= odata` on every clock with `sync`=1; reset value 8'h00 (memory map).
- Access type: I/O read if `status[6]`, I/O write if `status[4]`, INTA if `status[0]`, else memory.
- Memory hit i: memory type and `(addr & MEM_MASK[i]) == MEM_BASE[i]`; lowest index wins on overlap; only the winner asserts a strobe.
- I/O hit j: I/O type and `(addr[7:0] & IO_MASK[j]) == IO_BASE[j]`; lowest index wins.
- Strobes combinational: `mem_rd[i] = rd & hit_i`; `mem_we[i] = ~wr_n & hit_i & ~MEM_RO[i]`; same for I/O without RO.
- `idata`: INTA → `INTA_VEC`; memory hit → `mem_data[i]`; I/O hit → `io_data[j]`; otherwise 8'hFF.
- Writes to a RO region are dropped silently and do not pulse `unmapped`.
- `unmapped` pulses when `(rd | ~wr_n)` rises with no hit and type ≠ INTA.

## Timing
- Divider `div` counts 0..`CE_DIV`-1; `ce`=1 for one clock when `div`=`CE_DIV`-1 and `wait_cnt`=0; otherwise 0.
- Access start: first clock where `(rd | ~wr_n)` is 1 and was 0 the previous clock; if memory region i hit, `wait_cnt <= MEM_WAIT[i]*CE_DIV`.
- While `wait_cnt`≠0: decrement each clock, `div` frozen, `ce`=0; strobes and `idata` stay valid.
- Zero-wait access: `ce` cadence unchanged (one pulse every `CE_DIV` clocks).
- Start and terminal count on the same clock: the load wins; that `ce` pulse is suppressed.
- I/O and INTA accesses never insert wait states.
- Reset: `div`=0, `wait_cnt`=0, `status`=0, edge detector cleared, `ce`=0, `unmapped`=0; the first `ce` is `CE_DIV` clocks after reset deasserts. Reset during a wait aborts it immediately.
- Strobe outputs follow inputs combinationally; no added latency.

## Test plan
- Defaults plus region0 base 0x0000 mask 0xF000 RO, region1 base 0x1000 mask 0xFC00: reads 0x0123 → `mem_rd[0]`, `idata`=`mem_data[0]`; writes 0x13FF → `mem_we[1]`; writes 0x0010 → no strobe, no `unmapped`.
- Status 8'h40 on sync, `addr`=0xFAFA, `rd`=1 with port base 0xFA mask 0xFE → `io_rd[0]`=1, memory strobes 0; status 8'h10 with `wr_n`=0 → `io_we[0]`.
- `MEM_WAIT[1]`=3, `CE_DIV`=2: read 0x1000 → `ce` gap of exactly 6 extra clocks, then normal 1-in-2 cadence.
- Status 8'h23 (INTA) with `rd`=1 → `idata`=8'hFF; read of 0x8000 unmapped → `idata`=8'hFF, `unmapped` pulses one clock.
- Overlapping regions 0 and 1 both matching 0x1000 → only `mem_rd[0]`.
- Assert `reset` mid-wait → next clock `ce`=0, `status`=0; first `ce` exactly `CE_DIV` clocks after release.
